// File: rtl/he_pkg.sv
// Shared types and default sizing for the HE polynomial datapath.
package he_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int DEGREE_N   = 16;
  localparam int LANES      = 4;
  localparam int IN_BEATS   = 2*DEGREE_N/LANES;
  localparam int OUT_BEATS  = DEGREE_N/LANES;

  typedef logic [DATA_WIDTH-1:0] coeff_t;
  typedef enum logic {ACCUM, DRAIN} fold_state_e;
endpackage

// File: rtl/poly_fold_mod_if.sv
// Stream bus for poly_fold_mod: product beats in, folded beats out.
// Optional POLY_FOLD_MOD_CYCLIC_EN adds cyclic_i.
interface poly_fold_mod_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
);
  logic [DATA_WIDTH-1:0]       q_i;
`ifdef POLY_FOLD_MOD_CYCLIC_EN
  logic                        cyclic_i;
`endif
  logic                        valid_i;
  logic                        ready_o;
  logic [LANES*DATA_WIDTH-1:0] data_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [LANES*DATA_WIDTH-1:0] data_o;
  logic                        done_o;

`ifdef POLY_FOLD_MOD_CYCLIC_EN
  modport master (output q_i, cyclic_i, valid_i, data_i, ready_i,
                  input  ready_o, valid_o, data_o, done_o);
  modport slave  (input  q_i, cyclic_i, valid_i, data_i, ready_i,
                  output ready_o, valid_o, data_o, done_o);
`else
  modport master (output q_i, valid_i, data_i, ready_i,
                  input  ready_o, valid_o, data_o, done_o);
  modport slave  (input  q_i, valid_i, data_i, ready_i,
                  output ready_o, valid_o, data_o, done_o);
`endif
endinterface

// File: rtl/poly_fold_mod_lane.sv
// Per-lane fold arithmetic: modsub (negacyclic) or modadd (cyclic) against q.
module mod_fold_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  input  logic         cyclic,
  output logic [W-1:0] y
);
  logic [W:0]   sum;
  logic [W:0]   sum_red;
  logic [W-1:0] diff;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    sum_red = sum - {1'b0, q};
    diff    = a - b;
    // q=0 degenerates both paths to plain mod 2^W arithmetic
    if (cyclic) y = (sum >= {1'b0, q}) ? sum_red[W-1:0] : sum[W-1:0];
    else        y = (a < b) ? diff + q : diff;
  end
endmodule

// File: rtl/poly_fold_mod.sv
// Folds a 2N-coefficient product modulo x^N+1 (or x^N-1) and modulo q, streaming N results.
// Optional macro POLY_FOLD_MOD_CYCLIC_EN enables runtime cyclic folding via cyclic_i.
module poly_fold_mod #(
  parameter int DATA_WIDTH = 16,
  parameter int DEGREE_N   = 16,
  parameter int LANES      = 4
) (
  input logic            clk,
  input logic            rst,
  poly_fold_mod_if.slave bus
);
  import he_pkg::*;

  localparam int N_IN   = 2*DEGREE_N/LANES;
  localparam int N_OUT  = DEGREE_N/LANES;
  localparam int OB_W   = $clog2(N_OUT);
  localparam int BEAT_W = $clog2(N_IN);

  fold_state_e             state, state_nx;
  logic [BEAT_W-1:0]       beat;
  logic [OB_W-1:0]         obeat;
  logic [DATA_WIDTH-1:0]   q_reg;
  logic                    cyc_reg;
  logic                    acc_fire, out_fire;
  logic [OB_W-1:0]         slot;
  logic                    upper;

  assign acc_fire = bus.valid_i && bus.ready_o;
  assign out_fire = bus.valid_o && bus.ready_i;
  // Low beat bits address the coefficient row; MSB selects fill vs fold half
  assign slot     = beat[OB_W-1:0];
  assign upper    = beat[BEAT_W-1];

  always_comb begin
    state_nx    = state;
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    bus.done_o  = 1'b0;
    unique case (state)
      ACCUM: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i && (&beat)) state_nx = DRAIN;
      end
      DRAIN: begin
        bus.valid_o = 1'b1;
        if (bus.ready_i && (&obeat)) begin
          bus.done_o = 1'b1;
          state_nx   = ACCUM;
        end
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACCUM;
      beat    <= '0;
      obeat   <= '0;
      q_reg   <= '0;
`ifdef POLY_FOLD_MOD_CYCLIC_EN
      cyc_reg <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      // Both counters are powers of two and wrap to 0 at frame end
      if (acc_fire) beat  <= beat + BEAT_W'(1);
      if (out_fire) obeat <= obeat + OB_W'(1);
      if (acc_fire && beat == '0) begin
        q_reg   <= bus.q_i;
`ifdef POLY_FOLD_MOD_CYCLIC_EN
        cyc_reg <= bus.cyclic_i;
`endif
      end
    end
  end

`ifndef POLY_FOLD_MOD_CYCLIC_EN
  assign cyc_reg = 1'b0;
`endif

  // Coefficient k lives in bank (k % LANES), row (k / LANES)
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] bank [N_OUT];
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] fold;

    assign din = bus.data_i[j*DATA_WIDTH +: DATA_WIDTH];

    mod_fold_lane #(.W(DATA_WIDTH)) u_fold (
      .a      (bank[slot]),
      .b      (din),
      .q      (q_reg),
      .cyclic (cyc_reg),
      .y      (fold)
    );

    always_ff @(posedge clk) begin
      if (acc_fire) bank[slot] <= upper ? fold : din;
    end

    assign bus.data_o[j*DATA_WIDTH +: DATA_WIDTH] = bus.valid_o ? bank[obeat] : '0;
  end
endmodule

// File: tb/tb_poly_fold_mod.sv
// Bench for poly_fold_mod: vector table, corner sequences and random frames vs. a ring-arithmetic model.
module tb_poly_fold_mod;
  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 2;

  typedef logic [W-1:0] c_t;
  typedef struct {
    c_t q;
    bit cyc;
    c_t in_c[2*N];
    c_t exp_c[N];
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  poly_fold_mod_if #(.DATA_WIDTH(W), .LANES(L)) bus ();

  poly_fold_mod #(.DATA_WIDTH(W), .DEGREE_N(N), .LANES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (bus.done_o) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ring model: result k = in[k] -/+ in[k+N] reduced into [0, q) (q=0 means 2^W)
  function automatic c_t ref_coef(input c_t a, input c_t b, input c_t q, input bit cyc);
    int m;
    m = (q == 0) ? (1 << W) : int'(q);
    if (cyc) return c_t'((int'(a) + int'(b)) % m);
    return c_t'(((int'(a) - int'(b)) % m + m) % m);
  endfunction

  task automatic drive_frame(input vec_t v, input bit hold);
    for (int b = 0; b < 2*N/L; b++) begin
      int t;
      t = 0;
      @(negedge clk);
      bus.valid_i = 1'b1;
      // q/cyclic only matter on beat 0; scramble them afterwards
      bus.q_i = (b == 0) ? v.q : ~v.q;
`ifdef POLY_FOLD_MOD_CYCLIC_EN
      bus.cyclic_i = (b == 0) ? v.cyc : ~v.cyc;
`endif
      for (int j = 0; j < L; j++) bus.data_i[j*W +: W] = v.in_c[b*L+j];
      while (!bus.ready_o && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!bus.ready_o) begin
        chk("drv_timeout", 0, 1);
        bus.valid_i = 1'b0;
        return;
      end
    end
    if (!hold) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
  endtask

  task automatic collect_frame(input vec_t v, input int stall);
    for (int ob = 0; ob < N/L; ob++) begin
      int s;
      int t;
      bit seen;
      s = 0; t = 0; seen = 1'b0;
      forever begin
        @(negedge clk);
        if (seen) chk("valid_hold", int'(bus.valid_o), 1);
        if (bus.valid_o) begin
          seen = 1'b1;
          chk("ready_in_drain", int'(bus.ready_o), 0);
          for (int j = 0; j < L; j++)
            chk($sformatf("data[%0d]", ob*L+j), int'(bus.data_o[j*W +: W]), int'(v.exp_c[ob*L+j]));
          bus.ready_i = (s >= stall);
          #1;
          chk("done", int'(bus.done_o), (s >= stall && ob == N/L-1) ? 1 : 0);
          if (s >= stall) break;
          s++;
        end else begin
          bus.ready_i = 1'b0;
          t++;
          if (t > 200) begin
            chk("col_timeout", 0, 1);
            return;
          end
        end
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int stall);
    int d0;
    d0 = done_cnt;
    fork
      drive_frame(v, 1'b0);
      collect_frame(v, stall);
    join
    @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  vec_t vecs[$];
  vec_t v, va, vb;

  initial begin
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    bus.q_i     = '0;
`ifdef POLY_FOLD_MOD_CYCLIC_EN
    bus.cyclic_i = 1'b0;
`endif
    rst = 1'b1;
    #1;
    chk("rst_ready", int'(bus.ready_o), 1);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_done",  int'(bus.done_o), 0);
    chk("rst_data",  int'(bus.data_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    v.cyc = 1'b0;
    v.q = 8'd5;   v.in_c = '{1,2,3,4,4,3,2,0};         v.exp_c = '{2,4,1,4};       vecs.push_back(v);
    v.q = 8'd0;   v.in_c = '{0,0,0,0,1,0,0,0};         v.exp_c = '{255,0,0,0};     vecs.push_back(v);
    v.q = 8'd7;   v.in_c = '{6,0,5,1,0,6,5,2};         v.exp_c = '{6,1,0,6};       vecs.push_back(v);
    v.q = 8'd200; v.in_c = '{199,0,100,50,0,1,100,49}; v.exp_c = '{199,199,0,1};   vecs.push_back(v);
`ifdef POLY_FOLD_MOD_CYCLIC_EN
    v.cyc = 1'b1;
    v.q = 8'd5;   v.in_c = '{1,2,3,4,4,3,2,0};         v.exp_c = '{0,0,0,4};       vecs.push_back(v);
    v.cyc = 1'b0;
`endif
    // First vector doubles as the backpressure case (3 stall cycles per beat)
    foreach (vecs[i]) run_frame(vecs[i], (i == 0) ? 3 : 0);

    // Reset after two accepted beats discards the partial frame
    @(negedge clk);
    bus.valid_i = 1'b1; bus.q_i = 8'd7;
    bus.data_i = {8'd0, 8'd6};
    @(negedge clk);
    bus.data_i = {8'd1, 8'd5};
    @(negedge clk);
    bus.valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", int'(bus.ready_o), 1);
    chk("midrst_valid", int'(bus.valid_o), 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(vecs[0], 0);

    // Back-to-back frames with valid held high through the drain
    va = vecs[0];
    vb = vecs[0];
    vb.q = 8'd7;
    vb.exp_c = '{4,6,1,4};
    begin
      int d0;
      d0 = done_cnt;
      fork
        begin drive_frame(va, 1'b1); drive_frame(vb, 1'b0); end
        begin collect_frame(va, 0); collect_frame(vb, 1); end
      join
      @(posedge clk);
      #1;
      chk("b2b_done_pulses", done_cnt - d0, 2);
    end

    // Random in-contract frames against the ring model
    for (int r = 0; r < 16; r++) begin
      v.q = c_t'($urandom_range(0, 255));
`ifdef POLY_FOLD_MOD_CYCLIC_EN
      v.cyc = bit'($urandom_range(0, 1));
`else
      v.cyc = 1'b0;
`endif
      for (int k = 0; k < 2*N; k++)
        v.in_c[k] = (k == 2*N-1) ? c_t'(0) :
                    (v.q == 0) ? c_t'($urandom) : c_t'($urandom % int'(v.q));
      for (int k = 0; k < N; k++) v.exp_c[k] = ref_coef(v.in_c[k], v.in_c[k+N], v.q, v.cyc);
      run_frame(v, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/poly_fold_mod.md
Name: poly_fold_mod

Overview:
- Negacyclic reconstruction stage between the polynomial multiplier output path and relinearisation.
- Accepts the 2N-coefficient raw product as a stream of LANES-wide beats and folds it modulo x^N+1 and modulo q into N coefficients.
- Streams the N results out LANES per beat.
- Parametrised successor of the single-lane mod/recon FIFO path: multi-lane, runtime q, ring folding and a backpressured output.

Parameters:
- DATA_WIDTH, 16: coefficient width in bits.
- DEGREE_N, 16: ring degree N; power of two, >= 2*LANES.
- LANES, 4: coefficients per beat; power of two; divides N.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- q_i  in  DATA_WIDTH  modulus; latched on the first accepted beat of each frame.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- data_i  in  LANES*DATA_WIDTH  lane j = product coefficient beat*LANES+j; each coefficient < q.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts when valid_o && ready_i.
- data_o  out  LANES*DATA_WIDTH  lane j = result coefficient obeat*LANES+j.
- done_o  out  1  one-cycle pulse when the last output beat is accepted.

Behaviour:
- Reset (asynchronous, any state): state=ACCUM, beat and output counters=0, ready_o=1, valid_o=0, done_o=0, data_o=0, q register=0. Coefficient buffer is not reset. A reset mid-frame discards the partial frame; the next accepted beat starts a fresh frame.
- One frame = 2N/LANES input beats. The product's coefficient 2N-1 position carries 0.
- State ACCUM: ready_o=1, valid_o=0.
  - On each accepted beat b (counter 0..2N/LANES-1):
    - b < N/LANES: buf[b*LANES+j] <= data_i lane j.
    - Otherwise: k = b*LANES+j-N; buf[k] <= modsub(buf[k], lane j).
  - Beat 0 also latches q_i.
  - Accepting the last beat -> DRAIN on the next edge. No bubble cycles are required between beats.
- modsub(a,b): d = a-b in DATA_WIDTH bits; if a < b then d = d+q, truncated to DATA_WIDTH.
  - q=0 therefore yields arithmetic mod 2^DATA_WIDTH. This is a defined mode.
  - Inputs >= q are outside contract; the result is unspecified but must not hang the FSM.
- State DRAIN: ready_o=0, valid_o=1, data_o = buf[obeat*LANES +: LANES*DATA_WIDTH], read combinationally from the buffer register.
  - data_o is held stable while ready_i=0.
  - On accept, obeat increments.
  - Accept of beat N/LANES-1: done_o=1 that cycle (combinational on the accept), obeat=0, beat=0, -> ACCUM.
- Latency: last input beat accepted at edge t -> valid_o=1 with output beat 0 after edge t. Minimum frame period is 2N/LANES + N/LANES cycles.
- valid_i while in DRAIN is ignored (ready_o=0). Upstream must hold its beat.

Optional Feature:
- POLY_FOLD_MOD_CYCLIC_EN.
- Defined: adds input port cyclic_i (1 bit), latched with q on beat 0.
  - When latched 1, the fold uses modadd(a,b) = a+b, minus q if a+b >= q (wide sum, DATA_WIDTH+1 bits), giving reduction mod x^N-1.
  - When latched 0, the fold is negacyclic.
- Undefined: no cyclic_i port; folding is always negacyclic.

Decomposition:
- Shared package he_pkg:
  - coeff_t (logic [DATA_WIDTH-1:0]).
  - fold_state_e {ACCUM, DRAIN}.
  - Localparams IN_BEATS = 2*DEGREE_N/LANES and OUT_BEATS = DEGREE_N/LANES.
- Sub-module mod_fold_lane: combinational per-lane modsub/modadd of (a, b, q, cyclic), instantiated LANES times.

Test Plan:
- Negacyclic fold. Overrides N=4, LANES=2, W=8; q=5. Input coefficients [1,2,3,4,4,3,2,0], ready_i=1 -> outputs [2,4],[1,4]; done_o pulses once on the second output accept.
- Cyclic fold. With POLY_FOLD_MOD_CYCLIC_EN, cyclic_i=1 and the same input -> outputs [0,0],[0,4].
- Output backpressure. ready_i=0 for 3 cycles in DRAIN -> valid_o stays 1, data_o held at [2,4], ready_o stays 0; results are unchanged after release.
- Reset mid-frame. Assert rst after 2 accepted beats -> ready_o=1, valid_o=0 immediately; a full new frame then produces correct results.
- q=0 wrap. W=8; input [0,0,0,0,1,0,0,0] -> output coefficient 0 = 255, others 0.
- Back-to-back frames. valid_i held high across two frames with q=5 then q=7 -> ready_o=0 during drain; each frame is reduced with its own latched q; done_o pulses twice.
